// File: rtl/eight_bit_down_counter_pkg.sv
// Shared types and constants for the eight_bit_down_counter block.
// Holds the FSM state enumeration and the default counter width.
package eight_bit_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/eight_bit_down_counter.sv
// Presettable down counter with start/pause control and a one-cycle done pulse.
// Optional auto-reload on terminal count is enabled by defining AUTO_RELOAD_EN.
module eight_bit_down_counter
  import eight_bit_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_btn,
  input  logic [WIDTH-1:0] load_value,
  input  logic             preset_btn,
  input  logic             start_btn,
  input  logic             pause_btn,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done,
  output state_t           state
);

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk) begin
    if (reset_btn) begin
      reload <= '0;
    end else if (preset_btn) begin
      reload <= load_value;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_btn) begin
      count <= '0;
      state <= ST_IDLE;
      done  <= 1'b0;
    end else if (preset_btn) begin
      count <= load_value;
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_btn && (count != '0)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause_btn) begin
            state <= ST_PAUSE;
          end else if (count == WIDTH'(1)) begin
            done <= 1'b1;
`ifdef AUTO_RELOAD_EN
            // A zero reload value falls back to the plain stop-at-zero behaviour.
            count <= reload;
            state <= (reload != '0) ? ST_RUN : ST_DONE;
`else
            count <= '0;
            state <= ST_DONE;
`endif
          end else if (count == '0) begin
            // Defensive: never wrap below zero.
            state <= ST_IDLE;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
        ST_PAUSE: begin
          if (start_btn) begin
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_PAUSE);
  assign zero = (count == '0);

endmodule

// File: tb/tb_eight_bit_down_counter.sv
// Directed self-checking bench for eight_bit_down_counter.
// Inputs change #1 after a rising edge; outputs are checked at that point.
module tb_eight_bit_down_counter;
  import eight_bit_down_counter_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset_btn;
  logic [W-1:0] load_value;
  logic         preset_btn;
  logic         start_btn;
  logic         pause_btn;
  logic [W-1:0] count;
  logic         busy;
  logic         zero;
  logic         done;
  state_t       state;

  int total;
  int bad;

  eight_bit_down_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_btn  (reset_btn),
    .load_value (load_value),
    .preset_btn (preset_btn),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .count      (count),
    .busy       (busy),
    .zero       (zero),
    .done       (done),
    .state      (state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset_btn  = 1'b1;
    load_value = '0;
    preset_btn = 1'b0;
    start_btn  = 1'b0;
    pause_btn  = 1'b0;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_preset(input logic [W-1:0] v);
    load_value = v;
    preset_btn = 1'b1;
    tick();
    preset_btn = 1'b0;
  endtask

  task automatic do_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
  endtask

  task automatic test_reset();
    reset_btn = 1'b1;
    tick();
    tick();
    total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
    reset_btn = 1'b0;
    // Reset during RUN at count 5, held for two cycles
    do_preset(8'd10);
    do_start();
    for (int i = 0; i < 5; i++) tick();
    total++; if (count !== 8'd5) begin bad++; $display("FAIL run_pre_reset_count got=%0d exp=5", count); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_pre_reset_busy got=%b exp=1", busy); end
    reset_btn = 1'b1;
    start_btn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (count !== 8'd0) begin bad++; $display("FAIL midrun_reset_count cyc=%0d got=%0d exp=0", i, count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_reset_busy cyc=%0d got=%b exp=0", i, busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midrun_reset_done cyc=%0d got=%b exp=0", i, done); end
      total++; if (zero !== 1'b1) begin bad++; $display("FAIL midrun_reset_zero cyc=%0d got=%b exp=1", i, zero); end
    end
    reset_btn = 1'b0;
    start_btn = 1'b0;
  endtask

  task automatic test_countdown();
    logic [W-1:0] exp_cnt [4];
    logic         exp_done [4];
    exp_cnt  = '{8'd3, 8'd2, 8'd1, 8'd0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_preset(8'd3);
    total++; if (count !== 8'd3 || state !== ST_IDLE) begin bad++; $display("FAIL preset3 count=%0d state=%0d exp 3/%0d", count, state, ST_IDLE); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL preset3_busy got=%b exp=0", busy); end
    start_btn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start_btn = 1'b0;
      total++; if (count !== exp_cnt[i]) begin bad++; $display("FAIL cd_count step=%0d got=%0d exp=%0d", i, count, exp_cnt[i]); end
      total++; if (done !== exp_done[i]) begin bad++; $display("FAIL cd_done step=%0d got=%b exp=%b", i, done, exp_done[i]); end
    end
    total++; if (state !== ST_DONE || busy !== 1'b0 || zero !== 1'b1) begin bad++; $display("FAIL cd_terminal state=%0d busy=%b zero=%b exp %0d/0/1", state, busy, zero, ST_DONE); end
    // start in DONE is ignored; the block then rests in IDLE with count 0
    start_btn = 1'b1;
    tick();
    total++; if (state !== ST_IDLE || done !== 1'b0 || count !== 8'd0) begin bad++; $display("FAIL done_to_idle state=%0d done=%b count=%0d exp %0d/0/0", state, done, count, ST_IDLE); end
    tick();
    total++; if (state !== ST_IDLE || done !== 1'b0) begin bad++; $display("FAIL idle_start_at_zero state=%0d done=%b exp %0d/0", state, done, ST_IDLE); end
    start_btn = 1'b0;
  endtask

  task automatic test_pause();
    do_preset(8'd10);
    do_start();
    for (int i = 0; i < 3; i++) tick();
    total++; if (count !== 8'd7) begin bad++; $display("FAIL pause_pre_count got=%0d exp=7", count); end
    pause_btn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (count !== 8'd7 || busy !== 1'b1) begin bad++; $display("FAIL pause_hold cyc=%0d count=%0d busy=%b exp 7/1", i, count, busy); end
    end
    total++; if (state !== ST_PAUSE) begin bad++; $display("FAIL pause_state got=%0d exp=%0d", state, ST_PAUSE); end
    pause_btn = 1'b0;
    do_start();
    total++; if (count !== 8'd7 || state !== ST_RUN) begin bad++; $display("FAIL resume count=%0d state=%0d exp 7/%0d", count, state, ST_RUN); end
    tick();
    total++; if (count !== 8'd6 || busy !== 1'b1) begin bad++; $display("FAIL resume_dec1 count=%0d busy=%b exp 6/1", count, busy); end
    tick();
    total++; if (count !== 8'd5) begin bad++; $display("FAIL resume_dec2 got=%0d exp=5", count); end
    // pause wins over start while running
    pause_btn = 1'b1;
    start_btn = 1'b1;
    tick();
    total++; if (count !== 8'd5 || state !== ST_PAUSE) begin bad++; $display("FAIL pause_over_start count=%0d state=%0d exp 5/%0d", count, state, ST_PAUSE); end
    pause_btn = 1'b0;
    tick();
    start_btn = 1'b0;
    total++; if (count !== 8'd5 || state !== ST_RUN) begin bad++; $display("FAIL resume2 count=%0d state=%0d exp 5/%0d", count, state, ST_RUN); end
    tick();
    total++; if (count !== 8'd4) begin bad++; $display("FAIL resume2_dec got=%0d exp=4", count); end
  endtask

  task automatic test_zero_start();
    do_preset(8'd0);
    start_btn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (state !== ST_IDLE || busy !== 1'b0 || done !== 1'b0 || count !== 8'd0) begin
        bad++; $display("FAIL zero_start cyc=%0d state=%0d busy=%b done=%b count=%0d exp %0d/0/0/0", i, state, busy, done, count, ST_IDLE);
      end
    end
    start_btn = 1'b0;
  endtask

  task automatic test_preset_priority();
    do_preset(8'd6);
    do_start();
    tick();
    tick();
    total++; if (count !== 8'd4) begin bad++; $display("FAIL prio_pre_count got=%0d exp=4", count); end
    load_value = 8'd9;
    preset_btn = 1'b1;
    start_btn  = 1'b1;
    tick();
    preset_btn = 1'b0;
    start_btn  = 1'b0;
    total++; if (count !== 8'd9 || state !== ST_IDLE || busy !== 1'b0) begin bad++; $display("FAIL preset_over_run count=%0d state=%0d busy=%b exp 9/%0d/0", count, state, busy, ST_IDLE); end
    // preset on the would-be terminal edge suppresses done
    do_preset(8'd2);
    do_start();
    tick();
    total++; if (count !== 8'd1) begin bad++; $display("FAIL prio_at_one got=%0d exp=1", count); end
    do_preset(8'd7);
    total++; if (count !== 8'd7 || done !== 1'b0 || state !== ST_IDLE) begin bad++; $display("FAIL preset_at_terminal count=%0d done=%b state=%0d exp 7/0/%0d", count, done, state, ST_IDLE); end
    // reset beats preset
    reset_btn  = 1'b1;
    preset_btn = 1'b1;
    load_value = 8'd55;
    tick();
    reset_btn  = 1'b0;
    preset_btn = 1'b0;
    total++; if (count !== 8'd0 || zero !== 1'b1) begin bad++; $display("FAIL reset_over_preset count=%0d zero=%b exp 0/1", count, zero); end
    // full-scale load counts down from the top
    do_preset(8'hFF);
    do_start();
    tick();
    total++; if (count !== 8'hFE) begin bad++; $display("FAIL max_load_dec got=%0d exp=254", count); end
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [W-1:0] exp_cnt [5];
    logic         exp_done [5];
    exp_cnt  = '{8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_preset(8'd2);
    start_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start_btn = 1'b0;
      total++; if (count !== exp_cnt[i] || done !== exp_done[i] || state !== ST_RUN) begin
        bad++; $display("FAIL reload step=%0d count=%0d done=%b state=%0d exp %0d/%b/%0d", i, count, done, state, exp_cnt[i], exp_done[i], ST_RUN);
      end
    end
    pause_btn = 1'b1;
    tick();
    tick();
    pause_btn = 1'b0;
    total++; if (count !== 8'd2 || done !== 1'b0 || state !== ST_PAUSE) begin bad++; $display("FAIL reload_pause count=%0d done=%b state=%0d exp 2/0/%0d", count, done, state, ST_PAUSE); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    #1;
    test_reset();
    test_countdown();
    test_pause();
    test_zero_start();
    test_preset_priority();
`ifdef AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
